// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage.
package fetch_pkg;

   typedef struct packed {
      logic [31:2] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/fetch_fifo.sv
// Small fetch buffer: circular storage with head/tail pointers, count and synchronous flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter type entry_t = fetch_entry_t
) (
   input  logic   clk,
   input  logic   reset_n,
   input  logic   flush,
   input  logic   push,
   input  logic   pop,
   input  entry_t wdata,
   output entry_t rdata,
   output logic   empty,
   output logic   full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   entry_t          mem [DEPTH];
   logic [AW-1:0]   head_q, head_d;
   logic [AW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   count_q, count_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push) tail_d = tail_q + 1'b1;
         if (pop)  head_d = head_q + 1'b1;
         unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // When full, push and pop share the head slot; the read below still sees the old entry.
   always_ff @(posedge clk) begin
      if (push && !flush) mem[tail_q] <= wdata;
   end

   assign rdata = mem[head_q];
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory and buffers {pc, instr}.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0040_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic [29:0] imem_pc,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [29:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [29:0] out_pc,
   output logic [31:0] out_instr
);

   logic [29:0]  fetch_pc_q, fetch_pc_d;
   logic         push, pop;
   logic         empty, full;
   fetch_entry_t wdata, head;

   assign out_valid = ~empty;
   assign pop       = out_valid & out_ready;
   // Redirect wins over push; a pop frees a slot in the same cycle even when full.
   assign push      = ~redirect_valid & (~full | pop);

   assign wdata = '{pc: fetch_pc_q, instr: imem_instr};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc;
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 30'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fetch_pc_q <= RESET_PC[31:2];
      end else begin
         fetch_pc_q <= fetch_pc_d;
      end
   end

   fetch_fifo #(
      .DEPTH   (DEPTH),
      .entry_t (fetch_entry_t)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .flush   (redirect_valid),
      .push    (push),
      .pop     (pop),
      .wdata   (wdata),
      .rdata   (head),
      .empty   (empty),
      .full    (full)
   );

   assign imem_pc   = fetch_pc_q;
   assign out_pc    = out_valid ? head.pc    : 30'd0;
   assign out_instr = out_valid ? head.instr : NOP_INSTR;

endmodule
